// File: rtl/alu_req_arbiter_if.sv
// ----------------------------------------------------------------------------
// alu_req_arbiter_if
// Bundle of every bus signal around the ALU request arbiter:
//   REQ_*  : two requesters presenting ALU commands (valid/ready, packed {req1,req0})
//   RSP_*  : result return channel (valid/ready per requester, shared payload)
//   ALU_*  : pins of the shared alu_final instance (drive and capture)
// Modports:
//   slave  : the arbiter (accepts requests, returns responses, drives the ALU)
//   master : the environment (requesters, response sinks and the ALU itself)
// The width parameters must match those of the arbiter instance it connects to.
// ----------------------------------------------------------------------------
interface alu_req_arbiter_if #(
    parameter int width_OP  = 8,
    parameter int width_cmd = 4,
    parameter int width_RES = 16
);
    // Request side
    logic [1:0]             REQ_VALID;
    logic [1:0]             REQ_READY;
    logic [2*width_OP-1:0]  REQ_OPA;
    logic [2*width_OP-1:0]  REQ_OPB;
    logic [2*width_cmd-1:0] REQ_CMD;
    logic [1:0]             REQ_MODE;
    logic [1:0]             REQ_CIN;
    logic [3:0]             REQ_INP_VALID;

    // Response side
    logic [1:0]             RSP_VALID;
    logic [1:0]             RSP_READY;
    logic [width_RES-1:0]   RSP_RES;
    logic                   RSP_COUT;
    logic                   RSP_OFLOW;
    logic                   RSP_ERR;
    logic [2:0]             RSP_EGL;

    // ALU pins
    logic [width_OP-1:0]    ALU_OPA;
    logic [width_OP-1:0]    ALU_OPB;
    logic [width_cmd-1:0]   ALU_CMD;
    logic                   ALU_MODE;
    logic                   ALU_CIN;
    logic                   ALU_CE;
    logic [1:0]             ALU_INP_VALID;
    logic [width_RES-1:0]   ALU_RES;
    logic                   ALU_COUT;
    logic                   ALU_OFLOW;
    logic                   ALU_ERR;
    logic                   ALU_E;
    logic                   ALU_G;
    logic                   ALU_L;

    modport slave (
        input  REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
        output REQ_READY,
        output RSP_VALID, RSP_RES, RSP_COUT, RSP_OFLOW, RSP_ERR, RSP_EGL,
        input  RSP_READY,
        output ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
        input  ALU_RES, ALU_COUT, ALU_OFLOW, ALU_ERR, ALU_E, ALU_G, ALU_L
    );

    modport master (
        output REQ_VALID, REQ_OPA, REQ_OPB, REQ_CMD, REQ_MODE, REQ_CIN, REQ_INP_VALID,
        input  REQ_READY,
        input  RSP_VALID, RSP_RES, RSP_COUT, RSP_OFLOW, RSP_ERR, RSP_EGL,
        output RSP_READY,
        input  ALU_OPA, ALU_OPB, ALU_CMD, ALU_MODE, ALU_CIN, ALU_CE, ALU_INP_VALID,
        output ALU_RES, ALU_COUT, ALU_OFLOW, ALU_ERR, ALU_E, ALU_G, ALU_L
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// ----------------------------------------------------------------------------
// alu_req_arbiter
// Shares one alu_final between two requesters with round-robin arbitration.
// A transaction: accept one request (IDLE), drive the ALU for one ISSUE cycle
// plus LAT_ALU/LAT_MUL WAIT cycles, capture the ALU outputs, then hold them on
// the response channel (RESP) until the winning requester takes them.
// Ports:
//   CLK  : clock, rising edge
//   RST  : synchronous active-high reset (drops any in-flight operation)
//   bus  : slave side of alu_req_arbiter_if (REQ_*, RSP_*, ALU_* signals)
//   BUSY : 1 whenever the FSM is not in IDLE
// ----------------------------------------------------------------------------
module alu_req_arbiter #(
    parameter int width_OP  = 8,
    parameter int width_cmd = 4,
    parameter int width_RES = 16,
    parameter int LAT_ALU   = 2,
    parameter int LAT_MUL   = 3,
    parameter int MUL_CMD0  = 9,
    parameter int MUL_CMD1  = 10
) (
    input  logic               CLK,
    input  logic               RST,
    alu_req_arbiter_if.slave   bus,
    output logic               BUSY
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0]           lat_alu_c  = LAT_ALU[3:0];
    localparam logic [3:0]           lat_mul_c  = LAT_MUL[3:0];
    localparam logic [width_cmd-1:0] mul_cmd0_c = MUL_CMD0[width_cmd-1:0];
    localparam logic [width_cmd-1:0] mul_cmd1_c = MUL_CMD1[width_cmd-1:0];

    state_t                 state_reg;
    logic [1:0]             gnt_reg;       // one-hot owner of the current transaction
    logic                   last_reg;      // requester granted last (1 = req1)
    logic [3:0]             cnt_reg;
    logic                   busy_reg;

    // ALU drive registers double as the latched request fields; they are
    // zero whenever the FSM is outside ISSUE/WAIT.
    logic [width_OP-1:0]    alu_opa_reg;
    logic [width_OP-1:0]    alu_opb_reg;
    logic [width_cmd-1:0]   alu_cmd_reg;
    logic                   alu_mode_reg;
    logic                   alu_cin_reg;
    logic                   alu_ce_reg;
    logic [1:0]             alu_inp_valid_reg;

    logic [1:0]             rsp_valid_reg;
    logic [width_RES-1:0]   rsp_res_reg;
    logic                   rsp_cout_reg;
    logic                   rsp_oflow_reg;
    logic                   rsp_err_reg;
    logic [2:0]             rsp_egl_reg;

    // Per-requester views of the packed request fields
    logic [width_OP-1:0]    opa_arr  [2];
    logic [width_OP-1:0]    opb_arr  [2];
    logic [width_cmd-1:0]   cmd_arr  [2];
    logic [1:0]             inpv_arr [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign opa_arr[gi]  = bus.REQ_OPA[gi*width_OP +: width_OP];
            assign opb_arr[gi]  = bus.REQ_OPB[gi*width_OP +: width_OP];
            assign cmd_arr[gi]  = bus.REQ_CMD[gi*width_cmd +: width_cmd];
            assign inpv_arr[gi] = bus.REQ_INP_VALID[gi*2 +: 2];
        end
    endgenerate

    // Round-robin winner; only meaningful (and only exposed) in IDLE.
    logic [1:0] grant_next;
    logic       sel_next;

    always_comb begin
        grant_next = 2'b00;
        if (state_reg == IDLE) begin
            case (bus.REQ_VALID)
                2'b01:   grant_next = 2'b01;
                2'b10:   grant_next = 2'b10;
                2'b11:   grant_next = last_reg ? 2'b01 : 2'b10;
                default: grant_next = 2'b00;
            endcase
        end
    end

    assign sel_next = grant_next[1];

    logic is_mul;
    assign is_mul = alu_mode_reg && ((alu_cmd_reg == mul_cmd0_c) || (alu_cmd_reg == mul_cmd1_c));

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg         <= IDLE;
            gnt_reg           <= 2'b00;
            last_reg          <= 1'b1;       // req0 wins the first tie
            cnt_reg           <= 4'd0;
            busy_reg          <= 1'b0;
            alu_opa_reg       <= '0;
            alu_opb_reg       <= '0;
            alu_cmd_reg       <= '0;
            alu_mode_reg      <= 1'b0;
            alu_cin_reg       <= 1'b0;
            alu_ce_reg        <= 1'b0;
            alu_inp_valid_reg <= 2'b00;
            rsp_valid_reg     <= 2'b00;
            rsp_res_reg       <= '0;
            rsp_cout_reg      <= 1'b0;
            rsp_oflow_reg     <= 1'b0;
            rsp_err_reg       <= 1'b0;
            rsp_egl_reg       <= 3'b000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_next != 2'b00) begin
                        alu_opa_reg       <= opa_arr[sel_next];
                        alu_opb_reg       <= opb_arr[sel_next];
                        alu_cmd_reg       <= cmd_arr[sel_next];
                        alu_mode_reg      <= bus.REQ_MODE[sel_next];
                        alu_cin_reg       <= bus.REQ_CIN[sel_next];
                        alu_inp_valid_reg <= inpv_arr[sel_next];
                        alu_ce_reg        <= 1'b1;
                        gnt_reg           <= grant_next;
                        busy_reg          <= 1'b1;
                        state_reg         <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt_reg   <= is_mul ? lat_mul_c : lat_alu_c;
                    state_reg <= WAIT;
                end
                WAIT: begin
                    if (cnt_reg == 4'd1) begin
                        rsp_res_reg       <= bus.ALU_RES;
                        rsp_cout_reg      <= bus.ALU_COUT;
                        rsp_oflow_reg     <= bus.ALU_OFLOW;
                        rsp_err_reg       <= bus.ALU_ERR;
                        rsp_egl_reg       <= {bus.ALU_E, bus.ALU_G, bus.ALU_L};
                        rsp_valid_reg     <= gnt_reg;
                        alu_opa_reg       <= '0;
                        alu_opb_reg       <= '0;
                        alu_cmd_reg       <= '0;
                        alu_mode_reg      <= 1'b0;
                        alu_cin_reg       <= 1'b0;
                        alu_ce_reg        <= 1'b0;
                        alu_inp_valid_reg <= 2'b00;
                        cnt_reg           <= 4'd0;
                        state_reg         <= RESP;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                RESP: begin
                    // Only the owner's RSP_READY completes the transaction.
                    if ((bus.RSP_READY & gnt_reg) != 2'b00) begin
                        rsp_valid_reg <= 2'b00;
                        last_reg      <= gnt_reg[1];
                        busy_reg      <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.REQ_READY     = grant_next;
    assign bus.RSP_VALID     = rsp_valid_reg;
    assign bus.RSP_RES       = rsp_res_reg;
    assign bus.RSP_COUT      = rsp_cout_reg;
    assign bus.RSP_OFLOW     = rsp_oflow_reg;
    assign bus.RSP_ERR       = rsp_err_reg;
    assign bus.RSP_EGL       = rsp_egl_reg;
    assign bus.ALU_OPA       = alu_opa_reg;
    assign bus.ALU_OPB       = alu_opb_reg;
    assign bus.ALU_CMD       = alu_cmd_reg;
    assign bus.ALU_MODE      = alu_mode_reg;
    assign bus.ALU_CIN       = alu_cin_reg;
    assign bus.ALU_CE        = alu_ce_reg;
    assign bus.ALU_INP_VALID = alu_inp_valid_reg;
    assign BUSY              = busy_reg;
endmodule

// File: tb/tb_alu_req_arbiter.sv
// ----------------------------------------------------------------------------
// tb_alu_req_arbiter
// Directed bench for alu_req_arbiter. A small behavioural stand-in for
// alu_final (ADD, multiply, AND, compare flags, ERR on INP_VALID=00) sits on
// the ALU pins; expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_alu_req_arbiter;
    logic CLK;
    logic RST;
    logic BUSY;

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    alu_req_arbiter_if bus ();

    alu_req_arbiter dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ALU stand-in: combinational from the pins the arbiter drives
    always_comb begin
        bus.ALU_RES   = 16'h0000;
        bus.ALU_COUT  = 1'b0;
        bus.ALU_OFLOW = 1'b0;
        bus.ALU_ERR   = 1'b0;
        bus.ALU_E     = (bus.ALU_OPA == bus.ALU_OPB);
        bus.ALU_G     = (bus.ALU_OPA >  bus.ALU_OPB);
        bus.ALU_L     = (bus.ALU_OPA <  bus.ALU_OPB);
        if (bus.ALU_INP_VALID == 2'b00) begin
            bus.ALU_ERR = 1'b1;
        end else if (bus.ALU_MODE) begin
            case (bus.ALU_CMD)
                4'd0: begin
                    bus.ALU_RES  = {8'h00, bus.ALU_OPA} + {8'h00, bus.ALU_OPB};
                    bus.ALU_COUT = bus.ALU_RES[8];
                end
                4'd9, 4'd10: bus.ALU_RES = {8'h00, bus.ALU_OPA} * {8'h00, bus.ALU_OPB};
                default:     bus.ALU_ERR = 1'b1;
            endcase
        end else begin
            bus.ALU_RES = {8'h00, bus.ALU_OPA & bus.ALU_OPB};
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic set_req(input int r, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] cmd, input logic mode, input logic [1:0] inpv);
        bus.REQ_OPA[r*8 +: 8]       = a;
        bus.REQ_OPB[r*8 +: 8]       = b;
        bus.REQ_CMD[r*4 +: 4]       = cmd;
        bus.REQ_MODE[r]             = mode;
        bus.REQ_CIN[r]              = 1'b0;
        bus.REQ_INP_VALID[r*2 +: 2] = inpv;
        bus.REQ_VALID[r]            = 1'b1;
    endtask

    // Accept one request in IDLE, measure cycles to RSP_VALID, optionally ack.
    task automatic run_txn(input string tag, input logic [1:0] exp_grant, input int exp_lat,
                           input logic [15:0] exp_res, input logic [1:0] drop, input bit ack);
        int cycles;
        #1;
        check({tag, "_req_ready"}, {30'd0, bus.REQ_READY}, {30'd0, exp_grant});
        tick();
        bus.REQ_VALID = bus.REQ_VALID & ~drop;
        check({tag, "_alu_ce"}, {31'd0, bus.ALU_CE}, 32'd1);
        cycles = 0;
        while (bus.RSP_VALID == 2'b00 && cycles < 20) begin
            tick();
            cycles++;
        end
        check({tag, "_latency"}, cycles, exp_lat);
        check({tag, "_rsp_valid"}, {30'd0, bus.RSP_VALID}, {30'd0, exp_grant});
        check({tag, "_rsp_res"}, {16'd0, bus.RSP_RES}, {16'd0, exp_res});
        txn_no++;
        $display("txn %0d %s: grant=%b latency=%0d res=%h err=%b", txn_no, tag,
                 bus.RSP_VALID, cycles, bus.RSP_RES, bus.RSP_ERR);
        if (ack) begin
            bus.RSP_READY = exp_grant;
            tick();
            bus.RSP_READY = 2'b00;
            check({tag, "_rsp_drop"}, {30'd0, bus.RSP_VALID}, 32'd0);
        end
    endtask

    initial begin
        RST               = 1'b1;
        bus.REQ_VALID     = 2'b00;
        bus.REQ_OPA       = '0;
        bus.REQ_OPB       = '0;
        bus.REQ_CMD       = '0;
        bus.REQ_MODE      = 2'b00;
        bus.REQ_CIN       = 2'b00;
        bus.REQ_INP_VALID = 4'b0000;
        bus.RSP_READY     = 2'b00;
        tick();
        tick();
        RST = 1'b0;

        // Reset state
        check("rst_busy",      {31'd0, BUSY}, 32'd0);
        check("rst_rsp_valid", {30'd0, bus.RSP_VALID}, 32'd0);
        check("rst_alu_ce",    {31'd0, bus.ALU_CE}, 32'd0);
        check("rst_req_ready", {30'd0, bus.REQ_READY}, 32'd0);
        check("rst_rsp_res",   {16'd0, bus.RSP_RES}, 32'd0);

        // 1. req0 ADD 05+03, cycle-by-cycle
        set_req(0, 8'h05, 8'h03, 4'd0, 1'b1, 2'b11);
        #1;
        check("t1_req_ready", {30'd0, bus.REQ_READY}, 32'h1);
        tick();                                     // edge N
        bus.REQ_VALID = 2'b00;
        check("t1_busy",       {31'd0, BUSY}, 32'd1);
        check("t1_ready_off",  {30'd0, bus.REQ_READY}, 32'd0);
        check("t1_ce_n",       {31'd0, bus.ALU_CE}, 32'd1);
        check("t1_alu_opa",    {24'd0, bus.ALU_OPA}, 32'h05);
        check("t1_alu_opb",    {24'd0, bus.ALU_OPB}, 32'h03);
        check("t1_alu_inpv",   {30'd0, bus.ALU_INP_VALID}, 32'h3);
        tick();                                     // N+1
        check("t1_ce_n1",      {31'd0, bus.ALU_CE}, 32'd1);
        check("t1_rv_n1",      {30'd0, bus.RSP_VALID}, 32'd0);
        tick();                                     // N+2
        check("t1_ce_n2",      {31'd0, bus.ALU_CE}, 32'd1);
        check("t1_rv_n2",      {30'd0, bus.RSP_VALID}, 32'd0);
        tick();                                     // N+3
        check("t1_rv_n3",      {30'd0, bus.RSP_VALID}, 32'h1);
        check("t1_res",        {16'd0, bus.RSP_RES}, 32'h0008);
        check("t1_cout",       {31'd0, bus.RSP_COUT}, 32'd0);
        check("t1_err",        {31'd0, bus.RSP_ERR}, 32'd0);
        check("t1_egl",        {29'd0, bus.RSP_EGL}, 32'b010);
        check("t1_ce_off",     {31'd0, bus.ALU_CE}, 32'd0);
        check("t1_opa_off",    {24'd0, bus.ALU_OPA}, 32'd0);
        txn_no++;
        $display("txn %0d t1: grant=%b res=%h", txn_no, bus.RSP_VALID, bus.RSP_RES);
        bus.RSP_READY = 2'b01;
        tick();
        bus.RSP_READY = 2'b00;
        check("t1_rv_ack",     {30'd0, bus.RSP_VALID}, 32'd0);
        check("t1_busy_ack",   {31'd0, BUSY}, 32'd0);

        // 2. both valid from reset: order alternates 0,1,0,1
        RST = 1'b1;
        tick();
        RST = 1'b0;
        set_req(0, 8'h01, 8'h01, 4'd0, 1'b1, 2'b11);
        set_req(1, 8'h02, 8'h02, 4'd0, 1'b1, 2'b11);
        run_txn("t2a", 2'b01, 3, 16'h0002, 2'b00, 1'b1);
        run_txn("t2b", 2'b10, 3, 16'h0004, 2'b00, 1'b1);
        run_txn("t2c", 2'b01, 3, 16'h0002, 2'b00, 1'b1);
        run_txn("t2d", 2'b10, 3, 16'h0004, 2'b11, 1'b1);

        // 3. req1 multiply 0F*0F, left un-acked for the back-pressure test
        set_req(1, 8'h0F, 8'h0F, 4'd9, 1'b1, 2'b11);
        run_txn("t3", 2'b10, 4, 16'h00E1, 2'b10, 1'b0);

        // 4. back-pressure: response held, new req0 stalls
        set_req(0, 8'h03, 8'h04, 4'd0, 1'b1, 2'b11);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4_rv_hold",    {30'd0, bus.RSP_VALID}, 32'h2);
            check("t4_res_hold",   {16'd0, bus.RSP_RES}, 32'h00E1);
            check("t4_req_stall",  {30'd0, bus.REQ_READY}, 32'd0);
        end
        bus.RSP_READY = 2'b01;                      // non-owner ack is ignored
        tick();
        check("t4_rv_ignore", {30'd0, bus.RSP_VALID}, 32'h2);
        bus.RSP_READY = 2'b10;
        tick();
        bus.RSP_READY = 2'b00;
        check("t4_rv_ack",    {30'd0, bus.RSP_VALID}, 32'd0);
        run_txn("t4", 2'b01, 3, 16'h0007, 2'b01, 1'b1);

        // 5. reset during WAIT; pointer currently favours req1
        set_req(0, 8'h01, 8'h01, 4'd0, 1'b1, 2'b11);
        #1;
        tick();                                     // accept
        bus.REQ_VALID = 2'b00;
        tick();                                     // now in WAIT
        check("t5_ce_wait", {31'd0, bus.ALU_CE}, 32'd1);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t5_busy",    {31'd0, BUSY}, 32'd0);
        check("t5_ce",      {31'd0, bus.ALU_CE}, 32'd0);
        check("t5_rv",      {30'd0, bus.RSP_VALID}, 32'd0);
        for (int i = 0; i < 5; i++) tick();
        check("t5_rv_late", {30'd0, bus.RSP_VALID}, 32'd0);
        set_req(0, 8'h01, 8'h01, 4'd0, 1'b1, 2'b11);
        set_req(1, 8'h02, 8'h02, 4'd0, 1'b1, 2'b11);
        run_txn("t5", 2'b01, 3, 16'h0002, 2'b11, 1'b1);

        // 6. INP_VALID=00 is issued; ERR comes from the ALU
        set_req(1, 8'h05, 8'h05, 4'd0, 1'b1, 2'b00);
        run_txn("t6", 2'b10, 3, 16'h0000, 2'b10, 1'b0);
        check("t6_err", {31'd0, bus.RSP_ERR}, 32'd1);
        check("t6_egl", {29'd0, bus.RSP_EGL}, 32'b100);
        bus.RSP_READY = 2'b10;
        tick();
        bus.RSP_READY = 2'b00;
        check("t6_busy", {31'd0, BUSY}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
